// File: rtl/uart_pkg.sv
// Shared types and helpers for the UART transmit path.
// The BREAK state exists only when UART_TX_BREAK_EN is defined.
package uart_pkg;

   typedef enum logic [2:0] {
      StIdle,
      StStart,
      StData,
      StParity,
      StStop1,
      StStop2
`ifdef UART_TX_BREAK_EN
      , StBreak
`endif
   } tx_state_t;

   localparam logic PAR_EVEN = 1'b0;
   localparam logic PAR_ODD  = 1'b1;

   localparam logic STOP_ONE = 1'b0;
   localparam logic STOP_TWO = 1'b1;

   // Frame length in baud ticks: start + data + optional parity + 1 or 2 stop bits.
   function automatic int unsigned frame_len(input int unsigned data_width, input logic par_en,
                                             input logic stop2);
      return 2 + data_width + {31'd0, par_en} + {31'd0, stop2};
   endfunction

endpackage

// File: rtl/uart_tx_frame_if.sv
// Valid/ready word interface feeding the UART transmitter holding buffer.
interface uart_tx_frame_if #(
   parameter int unsigned DATA_WIDTH = 8
);
   logic [DATA_WIDTH-1:0] s_data;
   logic                  s_valid;
   logic                  s_ready;

   modport master (output s_data, output s_valid, input s_ready);
   modport slave  (input s_data, input s_valid, output s_ready);
endinterface

// File: rtl/uart_tx_shift.sv
// Data shift register, bit counter and parity for one UART frame.
// Loaded on START entry and shifted on each tick spent in DATA.
module uart_tx_shift #(
   parameter int unsigned DATA_WIDTH = 8
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  load_i,
   input  logic [DATA_WIDTH-1:0] data_i,
   input  logic                  shift_i,
   output logic                  bit_o,
   output logic                  last_o,
   output logic                  parity_o
);
   localparam int unsigned CntW = $clog2(DATA_WIDTH);

   logic [DATA_WIDTH-1:0] shift_q, shift_d;
   logic [CntW-1:0]       cnt_q, cnt_d;
   logic                  par_q, par_d;

   always_comb begin
      shift_d = shift_q;
      cnt_d   = cnt_q;
      par_d   = par_q;
      if (load_i) begin
         shift_d = data_i;
         cnt_d   = '0;
         par_d   = ^data_i;
      end else if (shift_i) begin
         shift_d = shift_q >> 1;
         cnt_d   = cnt_q + 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         shift_q <= '0;
         cnt_q   <= '0;
         par_q   <= 1'b0;
      end else begin
         shift_q <= shift_d;
         cnt_q   <= cnt_d;
         par_q   <= par_d;
      end
   end

   // Bit that will be on the line after this cycle, so the output register needs no extra stage.
   assign bit_o    = shift_d[0];
   assign last_o   = (cnt_q == CntW'(DATA_WIDTH - 1));
   assign parity_o = par_q;
endmodule

// File: rtl/uart_tx_frame.sv
// UART transmitter: holding buffer, frame FSM and registered TX line.
// Optional line-break support is enabled with UART_TX_BREAK_EN.
module uart_tx_frame
   import uart_pkg::*;
#(
   parameter int unsigned DATA_WIDTH = 8
) (
   input  logic            clk,
   input  logic            reset,
   input  logic            tick_en,
   uart_tx_frame_if.slave  s_if,
   input  logic            par_en,
   input  logic            par_type,
   input  logic            stop2,
`ifdef UART_TX_BREAK_EN
   input  logic            break_req,
`endif
   output logic            tx_out,
   output logic            busy,
   output logic            done
);
   tx_state_t             state_q, state_d;
   logic [DATA_WIDTH-1:0] hold_data_q, hold_data_d;
   logic                  hold_full_q, hold_full_d;
   logic                  tx_q, tx_d;
   logic                  done_q, done_d;
   logic                  par_en_q, par_en_d, par_type_q, par_type_d, stop2_q, stop2_d;
   logic                  start_entry, shift_bit, shift_last, shift_par;

`ifdef UART_TX_BREAK_EN
   localparam int unsigned BrkTicks = frame_len(DATA_WIDTH, 1'b1, 1'b1);
   localparam int unsigned BrkW     = $clog2(BrkTicks);

   logic [BrkW-1:0] brk_cnt_q, brk_cnt_d;
   logic            brk_done;

   assign brk_done = (brk_cnt_q == BrkW'(BrkTicks - 1));

   always_comb begin
      brk_cnt_d = brk_cnt_q;
      if (state_q != StBreak) brk_cnt_d = '0;
      else if (tick_en && !brk_done) brk_cnt_d = brk_cnt_q + 1'b1;
   end

   always_ff @(posedge clk) begin
      if (reset) brk_cnt_q <= '0;
      else       brk_cnt_q <= brk_cnt_d;
   end
`endif

   always_comb begin
      state_d = state_q;
      done_d  = 1'b0;
      if (tick_en) begin
         unique case (state_q)
            StIdle: begin
`ifdef UART_TX_BREAK_EN
               if (break_req) state_d = StBreak;
               else
`endif
               if (hold_full_q) state_d = StStart;
            end
            StStart:  state_d = StData;
            StData:   if (shift_last) state_d = par_en_q ? StParity : StStop1;
            StParity: state_d = StStop1;
            StStop1: begin
               if (stop2_q == STOP_TWO) begin
                  state_d = StStop2;
               end else begin
                  state_d = hold_full_q ? StStart : StIdle;
                  done_d  = 1'b1;
               end
            end
            StStop2: begin
               state_d = hold_full_q ? StStart : StIdle;
               done_d  = 1'b1;
            end
`ifdef UART_TX_BREAK_EN
            StBreak:  if (brk_done && !break_req) state_d = StIdle;
`endif
            default:  state_d = StIdle;
         endcase
      end
   end

   assign start_entry = (state_d == StStart) && (state_q != StStart);

   always_comb begin
      hold_data_d = hold_data_q;
      hold_full_d = hold_full_q;
      par_en_d    = par_en_q;
      par_type_d  = par_type_q;
      stop2_d     = stop2_q;
      if (start_entry) begin
         hold_full_d = 1'b0;
         par_en_d    = par_en;
         par_type_d  = par_type;
         stop2_d     = stop2;
      end
      if (s_if.s_valid && s_if.s_ready) begin
         hold_data_d = s_if.s_data;
         hold_full_d = 1'b1;
      end
   end

   // Line value is derived from the next state so tx_out lines up with the state register.
   always_comb begin
      tx_d = 1'b1;
      case (state_d)
         StStart:  tx_d = 1'b0;
         StData:   tx_d = shift_bit;
         StParity: tx_d = shift_par ^ (par_type_q == PAR_ODD);
`ifdef UART_TX_BREAK_EN
         StBreak:  tx_d = 1'b0;
`endif
         default:  tx_d = 1'b1;
      endcase
   end

   uart_tx_shift #(
      .DATA_WIDTH(DATA_WIDTH)
   ) u_shift (
      .clk      (clk),
      .reset    (reset),
      .load_i   (start_entry),
      .data_i   (hold_data_q),
      .shift_i  (tick_en && (state_q == StData)),
      .bit_o    (shift_bit),
      .last_o   (shift_last),
      .parity_o (shift_par)
   );

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q     <= StIdle;
         hold_data_q <= '0;
         hold_full_q <= 1'b0;
         tx_q        <= 1'b1;
         done_q      <= 1'b0;
         par_en_q    <= 1'b0;
         par_type_q  <= PAR_EVEN;
         stop2_q     <= STOP_ONE;
      end else begin
         state_q     <= state_d;
         hold_data_q <= hold_data_d;
         hold_full_q <= hold_full_d;
         tx_q        <= tx_d;
         done_q      <= done_d;
         par_en_q    <= par_en_d;
         par_type_q  <= par_type_d;
         stop2_q     <= stop2_d;
      end
   end

   assign s_if.s_ready = !hold_full_q;
   assign tx_out       = tx_q;
   assign busy         = (state_q != StIdle);
   assign done         = done_q;
endmodule

// File: tb/tb_uart_tx_frame.sv
// Bench for uart_tx_frame: fixed frame vectors, hand-written timing sequences and
// randomised traffic checked against a frame-level reference model.
module tb_uart_tx_frame;
   import uart_pkg::*;

   localparam int unsigned DW = 8;

   logic clk = 1'b0;
   logic reset, tick_en, par_en, par_type, stop2;
   logic tx_out, busy, done;
`ifdef UART_TX_BREAK_EN
   logic break_req = 1'b0;
`endif
   int   n_cmp = 0;
   int   n_fail = 0;

   uart_tx_frame_if #(.DATA_WIDTH(DW)) s_if ();

   uart_tx_frame #(
      .DATA_WIDTH(DW)
   ) dut (
      .clk      (clk),
      .reset    (reset),
      .tick_en  (tick_en),
      .s_if     (s_if),
      .par_en   (par_en),
      .par_type (par_type),
      .stop2    (stop2),
`ifdef UART_TX_BREAK_EN
      .break_req(break_req),
`endif
      .tx_out   (tx_out),
      .busy     (busy),
      .done     (done)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [DW-1:0] data;
      logic          pe;
      logic          pt;
      logic          s2;
      logic          flip;
      logic [15:0]   bits;
      int            len;
   } vec_t;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Line bits of one frame, index 0 first on the wire.
   function automatic void model_frame(input logic [DW-1:0] d, input logic pe, input logic pt,
                                       input logic s2, output logic [15:0] bits, output int len);
      bits    = '1;
      bits[0] = 1'b0;
      for (int i = 0; i < DW; i++) bits[1+i] = d[i];
      len = 1 + DW;
      if (pe) begin
         bits[len] = (^d) ^ pt;
         len++;
      end
      len += s2 ? 2 : 1;
   endfunction

   task automatic apply_vec(input vec_t v, input int k);
      s_if.s_data  = v.data;
      s_if.s_valid = 1'b1;
      par_en       = v.pe;
      par_type     = v.pt;
      stop2        = v.s2;
      chk($sformatf("v%0d ready", k), s_if.s_ready, 1);
      step();
      s_if.s_valid = 1'b0;
      chk($sformatf("v%0d pre-start", k), {tx_out, busy, s_if.s_ready}, 3'b100);
      step();
      for (int i = 0; i < v.len; i++) begin
         chk($sformatf("v%0d bit%0d", k, i), tx_out, v.bits[i]);
         chk($sformatf("v%0d busy/done%0d", k, i), {busy, done}, 2'b10);
         if (v.flip && i == 4) begin
            par_en   = ~par_en;
            par_type = ~par_type;
            stop2    = ~stop2;
         end
         step();
      end
      chk($sformatf("v%0d end", k), {tx_out, busy, done}, 3'b101);
      step();
      chk($sformatf("v%0d done pulse", k), done, 0);
   endtask

   vec_t          vecs[6];
   logic [15:0]   b1, b2;
   int            l1, l2, dones, frames;
   logic          exp_q[$];
   logic [DW-1:0] rd;
   logic          rpe, rpt, rs2;

   initial begin
      vecs[0] = '{8'hA5, 1'b1, PAR_EVEN, STOP_ONE, 1'b0, 16'h054A, 11};
      vecs[1] = '{8'hA5, 1'b1, PAR_ODD,  STOP_ONE, 1'b0, 16'h074A, 11};
      vecs[2] = '{8'hFF, 1'b0, PAR_EVEN, STOP_TWO, 1'b1, 16'h07FE, 11};
      vecs[3] = '{8'h3C, 1'b0, PAR_EVEN, STOP_ONE, 1'b0, 16'h0278, 10};
      vecs[4] = '{8'h00, 1'b1, PAR_EVEN, STOP_ONE, 1'b1, 16'h0400, 11};
      vecs[5] = '{8'h80, 1'b1, PAR_ODD,  STOP_TWO, 1'b0, 16'h0D00, 12};

      reset        = 1'b1;
      tick_en      = 1'b1;
      par_en       = 1'b0;
      par_type     = 1'b0;
      stop2        = 1'b0;
      s_if.s_data  = '0;
      s_if.s_valid = 1'b0;
      step();
      step();
      chk("reset held", {tx_out, busy, done, s_if.s_ready}, 4'b1001);
      reset = 1'b0;
      step();
      chk("reset released", {tx_out, busy, done, s_if.s_ready}, 4'b1001);

      for (int k = 0; k < 6; k++) apply_vec(vecs[k], k);

      // Back-to-back frames: second word handed over during the first frame's START.
      model_frame(8'h3C, 1'b0, 1'b0, 1'b0, b1, l1);
      model_frame(8'hC3, 1'b0, 1'b0, 1'b0, b2, l2);
      par_en = 1'b0;
      stop2  = 1'b0;
      s_if.s_data  = 8'h3C;
      s_if.s_valid = 1'b1;
      step();
      s_if.s_valid = 1'b0;
      step();
      dones = 0;
      for (int i = 0; i < 20; i++) begin
         if (i == 0) begin
            chk("b2b ready in start", s_if.s_ready, 1);
            s_if.s_data  = 8'hC3;
            s_if.s_valid = 1'b1;
         end
         if (i == 1) s_if.s_valid = 1'b0;
         chk($sformatf("b2b bit%0d", i), tx_out, (i < l1) ? b1[i] : b2[i-l1]);
         chk($sformatf("b2b busy%0d", i), busy, 1);
         if (done) dones++;
         step();
      end
      if (done) dones++;
      chk("b2b done count", dones, 2);
      chk("b2b idle after", {tx_out, busy}, 2'b10);
      step();

      // Baud gating: tick every 4th cycle, each bit held for four cycles.
      model_frame(8'h01, 1'b0, 1'b0, 1'b0, b1, l1);
      s_if.s_data = 8'h01;
      for (int c = 0; c <= 45; c++) begin
         tick_en      = (c % 4 == 3);
         s_if.s_valid = (c == 0);
         if (c >= 1 && c <= 3) chk($sformatf("baud idle c%0d", c), {tx_out, busy}, 2'b10);
         if (c == 3) chk("baud ready before start", s_if.s_ready, 0);
         if (c == 4) chk("baud ready after start", s_if.s_ready, 1);
         if (c >= 4 && c < 44) chk($sformatf("baud c%0d", c), tx_out, b1[(c-4)/4]);
         if (c == 43) chk("baud no early done", done, 0);
         if (c == 44) chk("baud done", {done, busy, tx_out}, 3'b101);
         if (c == 45) chk("baud done pulse", done, 0);
         step();
      end
      tick_en      = 1'b1;
      s_if.s_valid = 1'b0;

      // Reset during DATA bit 3 with a second word buffered.
      s_if.s_data  = 8'h5A;
      s_if.s_valid = 1'b1;
      step();
      s_if.s_valid = 1'b0;
      step();
      s_if.s_data  = 8'h66;
      s_if.s_valid = 1'b1;
      step();
      s_if.s_valid = 1'b0;
      step();
      step();
      step();
      chk("rst bit3 value", tx_out, 1);
      chk("rst buffer full", s_if.s_ready, 0);
      reset = 1'b1;
      step();
      chk("rst next cycle", {tx_out, busy, s_if.s_ready, done}, 4'b1010);
      reset = 1'b0;
      for (int i = 0; i < 30; i++) begin
         step();
         chk($sformatf("rst quiet%0d", i), {tx_out, busy, done}, 3'b100);
      end

      // Random traffic against the frame-level model; config travels with each word.
      frames = 0;
      dones  = 0;
      for (int cyc = 0; cyc < 1600; cyc++) begin
         if (busy) begin
            if (exp_q.size() == 0) chk("rnd unexpected frame bit", 1, 0);
            else chk($sformatf("rnd tx c%0d", cyc), tx_out, exp_q.pop_front());
         end else begin
            chk($sformatf("rnd idle c%0d", cyc), tx_out, 1);
         end
         if (done) dones++;
         if (s_if.s_valid) begin
            s_if.s_valid = 1'b0;
         end else if (s_if.s_ready && cyc < 1400 && $urandom_range(0, 2) == 0) begin
            rd  = DW'($urandom);
            rpe = 1'($urandom);
            rpt = 1'($urandom);
            rs2 = 1'($urandom);
            s_if.s_data  = rd;
            s_if.s_valid = 1'b1;
            par_en       = rpe;
            par_type     = rpt;
            stop2        = rs2;
            model_frame(rd, rpe, rpt, rs2, b1, l1);
            for (int i = 0; i < l1; i++) exp_q.push_back(b1[i]);
            frames++;
         end
         step();
      end
      chk("rnd all bits sent", exp_q.size(), 0);
      chk("rnd done per frame", dones, frames);
      chk("rnd final idle", {busy, tx_out}, 2'b01);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end
endmodule

// File: doc/uart_tx_frame.md
# uart_tx_frame

Parametrised UART transmitter, the next-generation serial TX path of the system's UART block. It serialises DATA_WIDTH-bit words into start / data (LSB first) / optional parity / 1-or-2 stop-bit frames. Bit timing comes from an external baud-tick enable. A one-entry holding buffer with a valid/ready handshake allows back-to-back frames with no idle gap. It sits between the system register/FIFO side and the TX pin, in the same clock domain as the rest of the UART.

## Interface
- DATA_WIDTH, 8, data bits per frame; legal range 5..9.
- clk  in  1  system clock; all logic is rising-edge.
- reset  in  1  synchronous, active-high reset.
- tick_en  in  1  baud enable; one bit period equals one cycle with tick_en=1.
- s_data  in  DATA_WIDTH  word to transmit.
- s_valid  in  1  s_data is valid.
- s_ready  out  1  holding buffer is empty; transfer happens when s_valid && s_ready.
- par_en  in  1  parity bit enable.
- par_type  in  1  parity type: 0 = even, 1 = odd.
- stop2  in  1  stop bits: 0 = one stop bit, 1 = two stop bits.
- tx_out  out  1  serial line, registered, idle high.
- busy  out  1  a frame is in progress (state is not IDLE).
- done  out  1  one-cycle pulse when the last stop bit completes.
- break_req  in  1  request a line break; present only with UART_TX_BREAK_EN.

## Operation
- Holding buffer (hold_data, hold_full) is filled on a handshake. It is drained when the FSM enters START.
- On entry to START, par_en, par_type and stop2 are latched into shadow registers. Changes to these inputs mid-frame have no effect on the current frame.
- FSM states: IDLE, START, DATA, PARITY, STOP1, STOP2, plus BREAK when UART_TX_BREAK_EN is defined.
- FSM transitions occur only on cycles with tick_en=1.
  - IDLE -> START when hold_full is set.
  - START -> DATA.
  - DATA stays in DATA until the bit counter reaches DATA_WIDTH-1.
  - DATA -> PARITY if par_en, else -> STOP1.
  - PARITY -> STOP1.
  - STOP1 -> STOP2 if stop2.
  - From the final stop state: -> START if hold_full is set, else -> IDLE.
- tx_out per state: START = 0; DATA = shift_reg[0], with a right shift on each tick; PARITY = ^data XOR par_type; STOP1/STOP2/IDLE = 1.
- Frame length in ticks: 2 + DATA_WIDTH + par_en + stop2.
- Bit counter width is $clog2(DATA_WIDTH). The counter clears on START.
- s_ready = !hold_full. A new word can be accepted one cycle after the buffer drains, including mid-frame.
- A handshake and a buffer drain in the same cycle are impossible, because s_ready is 0 while the buffer is full.

## Timing
- Reset values: tx_out=1, busy=0, done=0, s_ready=1, hold_full=0, state=IDLE.
- Reset mid-frame: the line returns to 1 on the next cycle and the buffered word is discarded.
- Latency: a word accepted in cycle N, with tick_en=1 in cycle N+1, puts tx_out=0 in cycle N+2.
- Each bit is held from one tick to the next. With tick_en constantly 1, each bit lasts one cycle.
- done is asserted in the cycle after the tick that ends the final stop bit, and only if the FSM goes to IDLE or START.
- busy is 1 from the START cycle through the final stop bit. For back-to-back frames busy stays 1 with no gap.
- tick_en=0 freezes the FSM and shift register; the handshake still operates.

## Configuration
- UART_TX_BREAK_EN defined:
  - The break_req port and the BREAK state exist.
  - In IDLE, break_req=1 on a tick -> BREAK, with tx_out=0.
  - BREAK lasts at least (2 + DATA_WIDTH + 2) ticks, then exits to IDLE on the first tick with break_req=0.
  - A pending buffered word waits until BREAK exits.
  - A request raised mid-frame waits for the frame to end.
- UART_TX_BREAK_EN undefined: no break_req port, no BREAK state, and no break counter logic.

## Structure
- Shared package uart_pkg holds:
  - the state enum (tx_state_t);
  - parity constants PAR_EVEN=1'b0 and PAR_ODD=1'b1;
  - the stop-bit encodings;
  - the frame-length function.
- One natural sub-module: uart_tx_shift, containing the shift register, bit counter and parity accumulator. It is loaded at START and shifted on DATA ticks.
- The FSM, holding buffer and output register stay in uart_tx_frame.

## Test plan
- Parity frames (DATA_WIDTH=8, tick_en=1, par_en=1):
  - 0xA5, even -> tx_out = 0,1,0,1,0,0,1,0,1,0,1 (11 cycles), then done pulse, then busy=0.
  - 0xA5, odd -> same sequence except the parity bit is 1.
- Back-to-back: send 0x3C, then 0xC3 while the first frame is in progress, par_en=0 -> 20 consecutive frame cycles with no idle bit between them, busy held high, exactly two done pulses.
- Two stop bits: stop2=1, par_en=0, 0xFF -> 0, then eight 1s, then 1,1 (11 ticks). Flipping stop2 mid-frame has no effect on that frame.
- Baud gating: tick_en every 4th cycle, 0x01 -> each bit lasts exactly 4 cycles, LSB first; s_ready returns to 1 one cycle after the frame's START entry.
- Reset mid-frame: reset asserted during DATA bit 3 with a word buffered -> next cycle tx_out=1, busy=0, s_ready=1; no done pulse; the buffered word is never sent.
